game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 128 ++++++++++++
 tb/tb_game_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frame-driven game flow controller: IDLE/SERVE/PLAY/LOST/OVER/WIN with lives tracking.
// Optional pause toggle is built only when GAME_SEQUENCER_PAUSE_EN is defined.
module game_sequencer #(
  parameter int LIVES_INIT        = 3,
  parameter int LOST_Y_PIXEL      = 470,
  parameter int LOST_DELAY_FRAMES = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FRAME_START,
  input  logic        BTN_RELEASE,
  input  logic        BTN_PAUSE,
  input  logic [9:0]  BALL_Y_PIXEL,
  input  logic [71:0] BLOCK_STATE,
  output logic        START_UPDATE,
  output logic        LOGIC_RESET,
  output logic [2:0]  LIVES,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_LOST   = 3'd4,
    S_OVER   = 3'd5,
    S_WIN    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        start_update_q, start_update_d;
  logic        logic_reset_q, logic_reset_d;
  logic        rel_prev_q, rel_prev_d;
  logic        rel_edge;
  logic        pause_edge;

`ifdef GAME_SEQUENCER_PAUSE_EN
  logic pause_prev_q;
  always_ff @(posedge CLK) begin
    if (RESET)            pause_prev_q <= 1'b0;
    else if (FRAME_START) pause_prev_q <= BTN_PAUSE;
  end
  assign pause_edge = FRAME_START & BTN_PAUSE & ~pause_prev_q;
`else
  logic unused_btn_pause;
  assign unused_btn_pause = BTN_PAUSE;
  assign pause_edge       = 1'b0;
`endif

  // Button edges compare against the sample taken at the previous frame, not the previous cycle.
  assign rel_edge = BTN_RELEASE & ~rel_prev_q;

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    cnt_d          = cnt_q;
    start_update_d = 1'b0;
    logic_reset_d  = 1'b0;
    rel_prev_d     = rel_prev_q;
    if (FRAME_START) begin
      rel_prev_d     = BTN_RELEASE;
      start_update_d = (state_q == S_SERVE) || (state_q == S_PLAY);
      case (state_q)
        S_IDLE: if (BTN_RELEASE) begin
          state_d       = S_SERVE;
          lives_d       = 3'(LIVES_INIT);
          logic_reset_d = 1'b1;
        end
        S_SERVE: if (BTN_RELEASE) state_d = S_PLAY;
        S_PLAY: begin
          if (BLOCK_STATE == '0) begin
            state_d = S_WIN;
          end else if (BALL_Y_PIXEL >= 10'(LOST_Y_PIXEL)) begin
            state_d = S_LOST;
            cnt_d   = '0;
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          end else if (pause_edge) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: if (pause_edge) state_d = S_PLAY;
        S_LOST: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == 6'(LOST_DELAY_FRAMES)) begin
            if (lives_q == 3'd0) begin
              state_d = S_OVER;
            end else begin
              state_d       = S_SERVE;
              logic_reset_d = 1'b1;
            end
          end
        end
        S_OVER, S_WIN: if (rel_edge) begin
          state_d       = S_IDLE;
          logic_reset_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      lives_q        <= 3'(LIVES_INIT);
      cnt_q          <= '0;
      start_update_q <= 1'b0;
      logic_reset_q  <= 1'b0;
      rel_prev_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      cnt_q          <= cnt_d;
      start_update_q <= start_update_d;
      logic_reset_q  <= logic_reset_d;
      rel_prev_q     <= rel_prev_d;
    end
  end

  assign START_UPDATE = start_update_q;
  assign LOGIC_RESET  = logic_reset_q;
  assign LIVES        = lives_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios then randomized frames, checked against a frame-level game model.
module tb_game_sequencer;

  localparam int INIT  = 3;
  localparam int LOSTY = 470;
  localparam int DELAY = 60;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, PAUSED = 3, LOST = 4, OVER = 5, WIN = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        btn_release = 1'b0;
  logic        btn_pause = 1'b0;
  logic [9:0]  ball_y = '0;
  logic [71:0] blocks = '1;
  logic        start_update;
  logic        logic_reset;
  logic [2:0]  lives;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: game status held as plain integers, LOST tracked as frames remaining.
  int m_state, m_lives, m_left, m_su, m_lr;
  bit m_rel_prev, m_pause_prev;

  game_sequencer dut (
    .CLK(clk), .RESET(reset), .FRAME_START(frame_start), .BTN_RELEASE(btn_release),
    .BTN_PAUSE(btn_pause), .BALL_Y_PIXEL(ball_y), .BLOCK_STATE(blocks),
    .START_UPDATE(start_update), .LOGIC_RESET(logic_reset), .LIVES(lives), .STATE(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_lives = INIT; m_left = 0;
    m_su = 0; m_lr = 0; m_rel_prev = 0; m_pause_prev = 0;
  endtask

  task automatic model_frame(input bit rel, input bit pause, input int y, input logic [71:0] blk);
    bit pause_pressed;
    pause_pressed = pause && !m_pause_prev;
`ifndef GAME_SEQUENCER_PAUSE_EN
    pause_pressed = 0;
`endif
    m_su = (m_state == SERVE || m_state == PLAY);
    m_lr = 0;
    case (m_state)
      IDLE:  if (rel) begin m_state = SERVE; m_lives = INIT; m_lr = 1; end
      SERVE: if (rel) m_state = PLAY;
      PLAY: begin
        if (blk == 0) m_state = WIN;
        else if (y >= LOSTY) begin m_state = LOST; m_lives = m_lives - 1; m_left = DELAY; end
        else if (pause_pressed) m_state = PAUSED;
      end
      PAUSED: if (pause_pressed) m_state = PLAY;
      LOST: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_lives == 0) m_state = OVER;
          else begin m_state = SERVE; m_lr = 1; end
        end
      end
      default: if (rel && !m_rel_prev) begin m_state = IDLE; m_lr = 1; end
    endcase
    m_rel_prev   = rel;
    m_pause_prev = pause;
  endtask

  // One clock cycle: drive at negedge, advance model, compare just after the rising edge.
  task automatic step(input bit fs, input bit rel, input bit pause, input int y,
                      input logic [71:0] blk, input bit rst);
    @(negedge clk);
    frame_start = fs; btn_release = rel; btn_pause = pause;
    ball_y = 10'(y); blocks = blk; reset = rst;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (fs) model_frame(rel, pause, y, blk);
    else begin m_su = 0; m_lr = 0; end
    check("state", int'(state), m_state);
    check("lives", int'(lives), m_lives);
    check("start_update", int'(start_update), m_su);
    check("logic_reset", int'(logic_reset), m_lr);
  endtask

  task automatic frame(input bit rel, input int y, input logic [71:0] blk);
    step(1, rel, 0, y, blk, 0);
  endtask

  initial begin
    logic [71:0] full;
    logic [71:0] rblk;
    int ry;
    full = '1;
    model_reset();

    // Reset state
    step(0, 0, 0, 0, full, 1);
    check("reset_state_is_idle", int'(state), IDLE);
    check("reset_lives_init", int'(lives), INIT);

    // Serve: IDLE -> SERVE with logic reset, no update kick
    frame(1, 100, full);
    check("serve_entry_state", int'(state), SERVE);
    check("serve_entry_lr", int'(logic_reset), 1);
    check("serve_entry_su", int'(start_update), 0);
    step(0, 0, 0, 100, full, 0);

    // Five frames in SERVE, each followed by one idle cycle
    for (int i = 0; i < 5; i++) begin
      frame(0, 100, full);
      check("serve_kick", int'(start_update), 1);
      step(0, 1, 0, 100, full, 0);
    end

    // Launch, then boundary row 469 stays in play, 470 is lost
    frame(1, 100, full);
    check("play_entry", int'(state), PLAY);
    frame(0, 469, full);
    check("y469_still_play", int'(state), PLAY);
    frame(0, 470, full);
    check("lost_state", int'(state), LOST);
    check("lost_lives", int'(lives), 2);
    for (int i = 0; i < DELAY; i++) begin
      frame(0, 470, full);
      check("lost_no_kick", int'(start_update), 0);
    end
    check("lost_to_serve", int'(state), SERVE);

    // WIN takes priority over a lost ball in the same frame
    frame(1, 100, full);
    frame(0, 480, '0);
    check("win_state", int'(state), WIN);
    check("win_lives_kept", int'(lives), 2);
    frame(1, 100, full);
    check("win_to_idle", int'(state), IDLE);

    // Burn all lives with the serve button held the whole time
    frame(1, 100, full);
    for (int k = 0; k < INIT; k++) begin
      frame(1, 100, full);
      frame(1, 600, full);
      for (int i = 0; i < DELAY; i++) step(1, 1, 0, 100, full, 0);
    end
    check("game_over", int'(state), OVER);
    check("game_over_lives", int'(lives), 0);
    for (int i = 0; i < 3; i++) frame(1, 100, full);
    check("over_held_button", int'(state), OVER);
    frame(0, 100, full);
    frame(1, 100, full);
    check("over_to_idle", int'(state), IDLE);

    // Reset with FRAME_START mid-LOST
    frame(1, 100, full);
    frame(1, 100, full);
    frame(0, 700, full);
    for (int i = 0; i < 10; i++) frame(0, 100, full);
    step(1, 1, 0, 100, full, 1);
    check("reset_mid_lost", int'(state), IDLE);

`ifdef GAME_SEQUENCER_PAUSE_EN
    frame(1, 100, full);
    frame(1, 100, full);
    step(1, 0, 1, 100, full, 0);
    check("pause_entry", int'(state), PAUSED);
    step(1, 0, 1, 100, full, 0);
    check("paused_no_kick", int'(start_update), 0);
    step(1, 0, 0, 100, full, 0);
    step(1, 0, 1, 100, full, 0);
    check("pause_exit", int'(state), PLAY);
    step(1, 0, 0, 100, full, 0);
    step(1, 0, 1, 100, full, 0);
    step(1, 0, 0, 100, full, 1);
    check("reset_mid_paused", int'(state), IDLE);
`endif

    // Randomized frames, gaps (including back-to-back frames) and occasional resets
    for (int n = 0; n < 1500; n++) begin
      ry   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(LOSTY, 1023)) : int'($urandom_range(0, LOSTY - 1));
      rblk = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 40) == 0) rblk = '0;
      else if ($urandom_range(0, 10) == 0) rblk = 72'd1 << $urandom_range(0, 71);
      step(1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, ry, rblk,
           $urandom_range(0, 300) == 0);
      for (int g = $urandom_range(0, 2); g > 0; g--)
        step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 600, '0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
